// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD receiver.
// Used by lcd_rx and lcd_rx_ddram.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IF8,
        ST_IF4_HI,
        ST_IF4_LO
    } rx_state_t;

    // Each opcode matches exactly the bytes whose highest set bit selects it.
    localparam logic [7:0] CMD_CLEAR   = 8'b0000_0001;
    localparam logic [7:0] CMD_HOME    = 8'b0000_001?;
    localparam logic [7:0] CMD_ENTRY   = 8'b0000_01??;
    localparam logic [7:0] CMD_DISPLAY = 8'b0000_1???;
    localparam logic [7:0] CMD_SHIFT   = 8'b0001_????;
    localparam logic [7:0] CMD_FUNC    = 8'b001?_????;
    localparam logic [7:0] CMD_CGRAM   = 8'b01??_????;
    localparam logic [7:0] CMD_DDRAM   = 8'b1???_????;

    localparam logic [3:0] NIB_8BIT = 4'h3;
    localparam logic [3:0] NIB_4BIT = 4'h2;

    localparam logic [6:0] ROW0_BASE = 7'h00;
    localparam logic [6:0] ROW1_BASE = 7'h40;
    localparam logic [6:0] ROW0_LAST = 7'h27;
    localparam logic [6:0] ROW1_LAST = 7'h67;
    localparam logic [7:0] SPACE     = 8'h20;

    // Address counter step with the two-row wrap of the controller's DDRAM map.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == ROW0_LAST)      return ROW1_BASE;
            else if (a == ROW1_LAST) return ROW0_BASE;
            else                     return a + 7'd1;
        end else begin
            if (a == ROW1_BASE)      return ROW0_LAST;
            else if (a == ROW0_BASE) return ROW1_LAST;
            else                     return a - 7'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_rx_ddram.sv
// Two-row display memory with per-cell valid bits for single-cycle clear.
// Cells never written since the last clear read back as a space.
module lcd_rx_ddram
    import lcd_pkg::*;
#(
    parameter int COLS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       wr_en,
    input  logic       wr_row,
    input  logic [3:0] wr_col,
    input  logic [7:0] wr_data,
    input  logic       rd_row,
    input  logic [3:0] rd_col,
    output logic [7:0] rd_data
);

    localparam int DEPTH = 2 * COLS;
    localparam int AW    = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic             wr_ok, rd_ok;

    function automatic logic [AW-1:0] cell_idx(input logic row, input logic [3:0] col);
        return row ? AW'(COLS) + AW'(col) : AW'(col);
    endfunction

    assign wr_ok  = wr_en && ({1'b0, wr_col} < 5'(COLS));
    assign rd_ok  = {1'b0, rd_col} < 5'(COLS);
    assign wr_idx = cell_idx(wr_row, wr_col);
    assign rd_idx = cell_idx(rd_row, rd_col);

    // NOTE: the cell array has no reset; the valid bits alone define cleared contents.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= '0;
            rd_data <= SPACE;
        end else begin
            rd_data <= (rd_ok && valid[rd_idx]) ? mem[rd_idx] : SPACE;
            if (clr)        valid         <= '0;
            else if (wr_ok) valid[wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/lcd_rx.sv
// HD44780 bus receiver: decodes enable strobes into bytes and models DDRAM.
// Define LCD_RX_BUSY_EN to model the busy period after clear/home.
module lcd_rx
    import lcd_pkg::*;
#(
    parameter int COLS        = 16,
    parameter int BUSY_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       rs,
    input  logic [3:0] data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] ac,
    output logic       mode_4bit,
    output logic [2:0] disp_ctrl,
    output logic       entry_inc,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_rs,
    output logic       proto_err,
    output logic       busy
);

    logic       en_q, rs_q, xfer;
    logic [3:0] data_q;
    rx_state_t  state, state_d;
    logic [3:0] hi_nib, hi_nib_d;
    logic       hi_rs, hi_rs_d;
    logic [6:0] ac_d;
    logic [2:0] disp_d;
    logic       inc_d, bv_d, perr_d, brs_d;
    logic [7:0] bout_d, full_byte;
    logic       wr_en, clr, busy_load;

    assign xfer      = en_q & ~en;
    assign full_byte = {hi_nib, data_q};
    assign mode_4bit = (state != ST_IF8);

    // NOTE: every signal gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d   = state;
        hi_nib_d  = hi_nib;
        hi_rs_d   = hi_rs;
        ac_d      = ac;
        disp_d    = disp_ctrl;
        inc_d     = entry_inc;
        bv_d      = 1'b0;
        perr_d    = 1'b0;
        bout_d    = byte_out;
        brs_d     = byte_rs;
        wr_en     = 1'b0;
        clr       = 1'b0;
        busy_load = 1'b0;
        if (xfer) begin
            if (busy) begin
                perr_d = 1'b1;
            end else begin
                case (state)
                    ST_IF8: begin
                        if (!rs_q && (data_q == NIB_8BIT || data_q == NIB_4BIT)) begin
                            bv_d   = 1'b1;
                            bout_d = {data_q, 4'h0};
                            brs_d  = 1'b0;
                            if (data_q == NIB_4BIT) state_d = ST_IF4_HI;
                        end else begin
                            perr_d = 1'b1;
                        end
                    end
                    ST_IF4_HI: begin
                        hi_nib_d = data_q;
                        hi_rs_d  = rs_q;
                        state_d  = ST_IF4_LO;
                    end
                    ST_IF4_LO: begin
                        state_d = ST_IF4_HI;
                        if (rs_q != hi_rs) begin
                            perr_d = 1'b1;
                        end else begin
                            bv_d   = 1'b1;
                            bout_d = full_byte;
                            brs_d  = rs_q;
                            if (rs_q) begin
                                // Only the visible window of each row is backed by storage.
                                wr_en = (ac[5:4] == 2'b00);
                                ac_d  = ac_step(ac, entry_inc);
                            end else begin
                                casez (full_byte)
                                    CMD_DDRAM:   ac_d = full_byte[6:0];
                                    CMD_CGRAM:   ;
                                    CMD_FUNC:    if (full_byte[4]) state_d = ST_IF8;
                                    CMD_SHIFT:   if (!full_byte[3]) ac_d = ac_step(ac, full_byte[2]);
                                    CMD_DISPLAY: disp_d = full_byte[2:0];
                                    CMD_ENTRY:   inc_d = full_byte[1];
                                    CMD_HOME: begin
                                        ac_d      = ROW0_BASE;
                                        busy_load = 1'b1;
                                    end
                                    CMD_CLEAR: begin
                                        ac_d      = ROW0_BASE;
                                        inc_d     = 1'b1;
                                        clr       = 1'b1;
                                        busy_load = 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                    default: state_d = ST_IF8;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 4'h0;
            state      <= ST_IF8;
            hi_nib     <= 4'h0;
            hi_rs      <= 1'b0;
            ac         <= ROW0_BASE;
            disp_ctrl  <= 3'b000;
            entry_inc  <= 1'b1;
            byte_valid <= 1'b0;
            byte_out   <= 8'h00;
            byte_rs    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            en_q       <= en;
            rs_q       <= rs;
            data_q     <= data;
            state      <= state_d;
            hi_nib     <= hi_nib_d;
            hi_rs      <= hi_rs_d;
            ac         <= ac_d;
            disp_ctrl  <= disp_d;
            entry_inc  <= inc_d;
            byte_valid <= bv_d;
            byte_out   <= bout_d;
            byte_rs    <= brs_d;
            proto_err  <= perr_d;
        end
    end

`ifdef LCD_RX_BUSY_EN
    localparam int BW = $clog2(BUSY_CYCLES + 1);
    logic [BW-1:0] busy_cnt;

    always_ff @(posedge clk) begin
        if (reset)                busy_cnt <= '0;
        else if (busy_load)       busy_cnt <= BW'(BUSY_CYCLES);
        else if (busy_cnt != '0)  busy_cnt <= busy_cnt - BW'(1);
    end

    assign busy = (busy_cnt != '0);
`else
    logic unused_busy;
    assign unused_busy = busy_load & (BUSY_CYCLES > 0);
    assign busy        = 1'b0;
`endif

    lcd_rx_ddram #(.COLS(COLS)) u_ddram (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_row  (ac[6]),
        .wr_col  (ac[3:0]),
        .wr_data (full_byte),
        .rd_row  (rd_addr[4]),
        .rd_col  (rd_addr[3:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_lcd_rx.sv
// Self-checking bench for lcd_rx: hand-computed vector table, directed corner
// sequences, and randomized traffic against a behavioural display model.
module tb_lcd_rx;

    localparam int COLS        = 16;
    localparam int BUSY_CYCLES = 2;
`ifdef LCD_RX_BUSY_EN
    localparam bit BUSY_BUILD = 1'b1;
`else
    localparam bit BUSY_BUILD = 1'b0;
`endif

    logic       clk, reset, en, rs;
    logic [3:0] data;
    logic [4:0] rd_addr;
    logic [7:0] rd_data, byte_out;
    logic [6:0] ac;
    logic [2:0] disp_ctrl;
    logic       mode_4bit, entry_inc, byte_valid, byte_rs, proto_err, busy;

    lcd_rx #(.COLS(COLS), .BUSY_CYCLES(BUSY_CYCLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .rs         (rs),
        .data       (data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .ac         (ac),
        .mode_4bit  (mode_4bit),
        .disp_ctrl  (disp_ctrl),
        .entry_inc  (entry_inc),
        .byte_valid (byte_valid),
        .byte_out   (byte_out),
        .byte_rs    (byte_rs),
        .proto_err  (proto_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: display as a flat array of characters, address as a
    // position along an 80-character ring (40 per row).
    bit       m_four, m_pend, m_hirs, m_inc;
    bit [3:0] m_hi;
    int       m_ac;
    bit [2:0] m_disp;
    bit [7:0] m_cells [2*COLS];
    bit       e_bv, e_perr, e_brs, e_busy;
    bit [7:0] e_bout;
    bit       auto_wait = 1'b1;

    function automatic int step_ac(input int a, input bit up);
        int pos;
        if (a <= 39)                pos = a;
        else if (a >= 64 && a <= 103) pos = a - 24;
        else                        return up ? (a + 1) & 127 : (a + 127) & 127;
        pos = up ? (pos + 1) % 80 : (pos + 79) % 80;
        return (pos < 40) ? pos : pos + 24;
    endfunction

    task automatic model_reset();
        m_four = 0; m_pend = 0; m_ac = 0; m_disp = 0; m_inc = 1;
        foreach (m_cells[i]) m_cells[i] = 8'h20;
    endtask

    task automatic model_exec(input bit r, input bit [7:0] b);
        if (r) begin
            if ((m_ac % 64) < COLS) m_cells[(m_ac / 64) * COLS + (m_ac % 64)] = b;
            m_ac = step_ac(m_ac, m_inc);
        end else if (b >= 8'h80) m_ac = int'(b) - 128;
        else if (b >= 8'h40) begin end
        else if (b >= 8'h20) begin if (b[4]) m_four = 0; end
        else if (b >= 8'h10) begin if (!b[3]) m_ac = step_ac(m_ac, b[2]); end
        else if (b >= 8'h08) m_disp = b[2:0];
        else if (b >= 8'h04) m_inc = b[1];
        else if (b >= 8'h02) begin m_ac = 0; e_busy = BUSY_BUILD; end
        else if (b == 8'h01) begin
            foreach (m_cells[i]) m_cells[i] = 8'h20;
            m_ac = 0; m_inc = 1; e_busy = BUSY_BUILD;
        end
    endtask

    task automatic model_nibble(input bit r, input bit [3:0] n);
        e_bv = 0; e_perr = 0; e_busy = 0;
        if (!m_four) begin
            if (!r && (n == 4'h3 || n == 4'h2)) begin
                e_bv = 1; e_bout = {n, 4'h0}; e_brs = 0;
                if (n == 4'h2) begin m_four = 1; m_pend = 0; end
            end else e_perr = 1;
        end else if (!m_pend) begin
            m_pend = 1; m_hi = n; m_hirs = r;
        end else begin
            m_pend = 0;
            if (r != m_hirs) e_perr = 1;
            else begin
                e_bv = 1; e_bout = {m_hi, n}; e_brs = r;
                model_exec(r, {m_hi, n});
            end
        end
    endtask

    // One enable strobe; returns #1 after the edge that sees en fall.
    task automatic drive_nibble(input bit r, input bit [3:0] n);
        @(negedge clk); en = 1'b1; rs = r; data = n;
        @(negedge clk); en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic xfer_nibble(input bit r, input bit [3:0] n);
        drive_nibble(r, n);
        model_nibble(r, n);
        check("byte_valid", byte_valid, e_bv);
        check("proto_err", proto_err, e_perr);
        if (e_bv) begin
            check("byte_out", byte_out, e_bout);
            check("byte_rs", byte_rs, e_brs);
        end
        check("ac", ac, m_ac);
        check("disp_ctrl", disp_ctrl, m_disp);
        check("entry_inc", entry_inc, m_inc);
        check("mode_4bit", mode_4bit, m_four);
        check("busy", busy, e_busy);
        if (e_busy && auto_wait) repeat (BUSY_CYCLES + 1) @(posedge clk);
    endtask

    task automatic send_byte(input bit r, input bit [7:0] b);
        xfer_nibble(r, b[7:4]);
        xfer_nibble(r, b[3:0]);
    endtask

    task automatic read_cell(input int idx, input bit [7:0] exp);
        @(negedge clk); rd_addr = 5'(idx);
        @(posedge clk); #1;
        check($sformatf("rd_data[%0d]", idx), rd_data, exp);
    endtask

    typedef struct {
        bit       rs;
        bit [7:0] b;
        bit [6:0] ac;
        bit [2:0] disp;
        bit       inc;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];
    bit [7:0] hand_cells [2*COLS];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // {rs, byte, ac after, disp_ctrl after, entry_inc after}
        tbl = '{
            '{0, 8'h28, 7'h00, 3'b000, 1}, '{0, 8'h0C, 7'h00, 3'b100, 1},
            '{0, 8'h06, 7'h00, 3'b100, 1}, '{0, 8'h01, 7'h00, 3'b100, 1},
            '{1, 8'h49, 7'h01, 3'b100, 1}, '{1, 8'h74, 7'h02, 3'b100, 1},
            '{1, 8'h73, 7'h03, 3'b100, 1}, '{0, 8'hA7, 7'h27, 3'b100, 1},
            '{1, 8'h41, 7'h40, 3'b100, 1}, '{1, 8'h42, 7'h41, 3'b100, 1},
            '{0, 8'h04, 7'h41, 3'b100, 0}, '{1, 8'h43, 7'h40, 3'b100, 0},
            '{0, 8'h10, 7'h27, 3'b100, 0}, '{0, 8'h14, 7'h40, 3'b100, 0},
            '{0, 8'h18, 7'h40, 3'b100, 0}, '{0, 8'h80, 7'h00, 3'b100, 0},
            '{0, 8'h10, 7'h67, 3'b100, 0}, '{0, 8'h14, 7'h00, 3'b100, 0},
            '{0, 8'h06, 7'h00, 3'b100, 1}, '{0, 8'h0F, 7'h00, 3'b111, 1},
            '{0, 8'hA5, 7'h25, 3'b111, 1}, '{1, 8'h55, 7'h26, 3'b111, 1},
            '{0, 8'h8F, 7'h0F, 3'b111, 1}, '{1, 8'h5A, 7'h10, 3'b111, 1},
            '{1, 8'h5B, 7'h11, 3'b111, 1}, '{0, 8'h45, 7'h11, 3'b111, 1},
            '{0, 8'h00, 7'h11, 3'b111, 1}, '{0, 8'h02, 7'h00, 3'b111, 1}
        };
        foreach (hand_cells[i]) hand_cells[i] = 8'h20;
        hand_cells[0] = 8'h49; hand_cells[1] = 8'h74; hand_cells[2] = 8'h73;
        hand_cells[15] = 8'h5A; hand_cells[16] = 8'h42; hand_cells[17] = 8'h43;

        en = 0; rs = 0; data = 0; rd_addr = 0; reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 0;
        model_reset();

        check("rst_ac", ac, 0);
        check("rst_mode_4bit", mode_4bit, 0);
        check("rst_disp_ctrl", disp_ctrl, 0);
        check("rst_entry_inc", entry_inc, 1);
        check("rst_rd_data", rd_data, 8'h20);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_busy", busy, 0);

        // Illegal transfers while in 8-bit mode.
        xfer_nibble(1'b1, 4'h3);
        check("if8_rs1_err", proto_err, 1);
        xfer_nibble(1'b0, 4'h5);
        check("if8_bad_nibble_err", proto_err, 1);

        // Power-on init sequence.
        for (int i = 0; i < 3; i++) begin
            xfer_nibble(1'b0, 4'h3);
            check("init_0x30", byte_out, 8'h30);
        end
        xfer_nibble(1'b0, 4'h2);
        check("init_0x20", byte_out, 8'h20);
        check("init_mode_4bit", mode_4bit, 1);

        for (int i = 0; i < NV; i++) begin
            send_byte(tbl[i].rs, tbl[i].b);
            check($sformatf("tbl%0d_valid", i), byte_valid, 1);
            check($sformatf("tbl%0d_byte", i), byte_out, tbl[i].b);
            check($sformatf("tbl%0d_rs", i), byte_rs, tbl[i].rs);
            check($sformatf("tbl%0d_ac", i), ac, tbl[i].ac);
            check($sformatf("tbl%0d_disp", i), disp_ctrl, tbl[i].disp);
            check($sformatf("tbl%0d_inc", i), entry_inc, tbl[i].inc);
            if (i == 3) for (int c = 0; c < 2*COLS; c++) read_cell(c, 8'h20);
        end
        for (int c = 0; c < 2*COLS; c++) read_cell(c, hand_cells[c]);

        // rs changes between the two halves of a byte.
        xfer_nibble(1'b0, 4'h4);
        xfer_nibble(1'b1, 4'h1);
        check("mismatch_err", proto_err, 1);
        check("mismatch_no_valid", byte_valid, 0);
        send_byte(1'b0, 8'h0C);
        check("after_mismatch_valid", byte_valid, 1);
        check("after_mismatch_disp", disp_ctrl, 3'b100);

        // Function set with DL=1 drops back to 8-bit mode.
        send_byte(1'b0, 8'h30);
        check("funcset_mode8", mode_4bit, 0);
        xfer_nibble(1'b0, 4'h2);
        check("funcset_mode4", mode_4bit, 1);

`ifdef LCD_RX_BUSY_EN
        auto_wait = 1'b0;
        send_byte(1'b0, 8'h01);
        check("busy_after_clear", busy, 1);
        drive_nibble(1'b0, 4'h0);
        check("busy_drop_err", proto_err, 1);
        check("busy_drop_no_valid", byte_valid, 0);
        check("busy_released", busy, 0);
        auto_wait = 1'b1;
        send_byte(1'b0, 8'h0D);
        check("after_busy_valid", byte_valid, 1);
        check("after_busy_disp", disp_ctrl, 3'b101);
`else
        send_byte(1'b0, 8'h01);
        check("no_busy_after_clear", busy, 0);
        send_byte(1'b0, 8'h0D);
        check("after_clear_disp", disp_ctrl, 3'b101);
`endif

        for (int it = 0; it < 150; it++) begin
            int       k;
            int       p;
            bit [7:0] b;
            k = $urandom_range(0, 11);
            b = 8'($urandom);
            p = $urandom_range(0, 79);
            case (k)
                0, 1, 2, 3, 4: send_byte(1'b1, b);
                5:  send_byte(1'b0, 8'h80 | 8'((p < 40) ? p : p + 24));
                6:  send_byte(1'b0, 8'h04 | (b & 8'h03));
                7:  send_byte(1'b0, 8'h08 | (b & 8'h07));
                8:  send_byte(1'b0, 8'h10 | (b & 8'h0F));
                9:  send_byte(1'b0, 8'h40 | (b & 8'h3F));
                10: begin
                    xfer_nibble(1'b0, b[7:4]);
                    xfer_nibble(1'b1, b[3:0]);
                end
                default: send_byte(1'b0, b[0] ? 8'h01 : (8'h02 | (b & 8'h01)));
            endcase
        end
        for (int c = 0; c < 2*COLS; c++) read_cell(c, m_cells[c]);

        // Reset between the two nibbles of a byte.
        xfer_nibble(1'b1, 4'h4);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_reset();
        check("midreset_mode", mode_4bit, 0);
        xfer_nibble(1'b0, 4'h3);
        check("midreset_valid", byte_valid, 1);
        check("midreset_byte", byte_out, 8'h30);
        read_cell(0, 8'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_rx.md
LCD_RX -- requirements
Module: lcd_rx

Interface
REQ-001 Parameter: COLS, 16, visible columns per row; DDRAM holds 2 rows of COLS cells.
REQ-002 Parameter: BUSY_CYCLES, 2, busy duration after clear/home, used only when LCD_RX_BUSY_EN is defined.
REQ-003 Port: clk  input  1  clock, all logic rising-edge.
REQ-004 Port: reset  input  1  synchronous, active-high.
REQ-005 Port: en  input  1  HD44780 enable strobe, synchronous to clk, high at least 1 cycle.
REQ-006 Port: rs  input  1  register select (0 command, 1 data).
REQ-007 Port: data  input  4  bus nibble (DB7..DB4).
REQ-008 Port: rd_addr  input  5  cell index {row, col[3:0]}.
REQ-009 Port: rd_data  output  8  cell contents, 1-cycle registered latency.
REQ-010 Port: ac  output  7  DDRAM address counter.
REQ-011 Port: mode_4bit  output  1  interface in 4-bit mode.
REQ-012 Port: disp_ctrl  output  3  {D, C, B} from display control.
REQ-013 Port: entry_inc  output  1  I/D bit of entry mode.
REQ-014 Port: byte_valid  output  1  one-cycle pulse per completed transfer; byte_out/byte_rs valid that cycle.
REQ-015 Port: byte_out  output  8; byte_rs  output  1.
REQ-016 Port: proto_err  output  1  one-cycle pulse on illegal transfer.
REQ-017 Port: busy  output  1  model busy flag (constant 0 without LCD_RX_BUSY_EN).

Function
REQ-018 Strobe: register en, rs, data each cycle; transfer event when en_q=1 and en=0, capturing rs_q and data_q.
REQ-019 FSM states: IF8, IF4_HI, IF4_LO.
REQ-020 IF8: rs=0, nibble 0x3 -> byte_valid with byte_out 0x30, stay IF8; nibble 0x2 -> byte_out 0x20, go IF4_HI; any other nibble or rs=1 -> proto_err, no state change.
REQ-021 IF4_HI: store nibble and rs, go IF4_LO; IF4_LO: assemble {hi, lo}, pulse byte_valid, execute, go IF4_HI.
REQ-022 rs mismatch between hi and lo nibbles -> proto_err, byte discarded, go IF4_HI.
REQ-023 Command decode by highest set bit: 0x01 clear (all cells read 0x20, ac=0, entry_inc=1); 0x02/0x03 home (ac=0); 0x04-0x07 entry_inc=bit1; 0x08-0x0F disp_ctrl=bit2..0; 0x10-0x1F with bit3=0 moves ac +1 (bit2=1) or -1, bit3=1 ignored; 0x20-0x3F function set, bit4=1 returns to IF8; 0x40-0x7F ignored; 0x80-0xFF ac=byte[6:0].
REQ-024 Data write (rs=1): store to cell {ac[6], ac[3:0]} only if ac[5:4]=0 and ac[3:0]<COLS; then step ac per entry_inc.
REQ-025 ac stepping: increment 0x27->0x40, 0x67->0x00; decrement 0x40->0x27, 0x00->0x67.
REQ-026 Clear completes in one cycle via per-cell valid bits; invalid cells read 0x20.
REQ-027 Read and write of same cell in same cycle: rd_data returns pre-write value.

Reset
REQ-028 Reset: state IF8, ac=0, mode_4bit=0, disp_ctrl=0, entry_inc=1, all cells invalid, rd_data=0x20, byte_valid=proto_err=busy=0.
REQ-029 Reset mid-byte discards the pending hi nibble.

Configuration
REQ-030 LCD_RX_BUSY_EN defined: clear/home hold busy=1 for BUSY_CYCLES cycles after execution; transfer events while busy -> proto_err, dropped, FSM unchanged.
REQ-031 LCD_RX_BUSY_EN undefined: busy tied 0, no transfer dropped.

Structure
REQ-032 Package lcd_pkg: command opcodes, FSM state typedef, row base addresses 0x00/0x40, wrap limits 0x27/0x67, space code 0x20.
REQ-033 Sub-module lcd_rx_ddram: 2*COLS x 8 storage, valid bits, single-cycle clear, registered read port.

Verification
REQ-034 Init nibbles 3,3,3,2 (rs=0) -> three byte_out 0x30, one 0x20, mode_4bit=1.
REQ-035 After init, bytes 0x28,0x0C,0x06,0x01 -> disp_ctrl=3'b100, entry_inc=1, ac=0, every rd_data 0x20.
REQ-036 Data 'I','t','s' at ac=0 -> cells 0..2 = 0x49,0x74,0x73, ac=3.
REQ-037 Command 0xA7 then data 0x41 -> ac 0x27->0x40, no cell written; data 0x42 -> cell 16 = 0x42.
REQ-038 Hi nibble rs=0, lo nibble rs=1 -> proto_err pulse, no byte_valid, next pair decodes normally.
REQ-039 LCD_RX_BUSY_EN, BUSY_CYCLES=2: transfer one cycle after 0x01 -> proto_err, dropped; transfer after busy falls accepted.
